// File: rtl/ds_operand_scoreboard_if.sv
// Decode-stage operand/hazard bundle: source addresses, regfile data, per-stage writer info,
// long-writer completion/flush inputs and the resolved operands plus ds_ready_go outputs.
interface ds_operand_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NFWD   = 3
);
  localparam int AW = $clog2(NREG);

  logic                   ds_valid;
  logic                   es_allowin;
  logic [AW-1:0]          rj_addr;
  logic [AW-1:0]          rkd_addr;
  logic                   rj_use;
  logic                   rkd_use;
  logic [AW-1:0]          ds_dest;
  logic                   ds_gr_we;
  logic                   ds_is_long;
  logic [DATA_W-1:0]      rf_rdata1;
  logic [DATA_W-1:0]      rf_rdata2;
  logic [NFWD-1:0]        fwd_we;
  logic [NFWD*AW-1:0]     fwd_dest;
  logic [NFWD*DATA_W-1:0] fwd_data;
  logic [NFWD-1:0]        fwd_rdy;
  logic                   long_done;
  logic [AW-1:0]          long_dest;
  logic                   flush;
  logic [DATA_W-1:0]      rj_value;
  logic [DATA_W-1:0]      rkd_value;
  logic                   ds_ready_go;
  logic                   long_pending;

  modport master (
    output ds_valid, es_allowin, rj_addr, rkd_addr, rj_use, rkd_use,
           ds_dest, ds_gr_we, ds_is_long, rf_rdata1, rf_rdata2,
           fwd_we, fwd_dest, fwd_data, fwd_rdy, long_done, long_dest, flush,
    input  rj_value, rkd_value, ds_ready_go, long_pending
  );

  modport slave (
    input  ds_valid, es_allowin, rj_addr, rkd_addr, rj_use, rkd_use,
           ds_dest, ds_gr_we, ds_is_long, rf_rdata1, rf_rdata2,
           fwd_we, fwd_dest, fwd_data, fwd_rdy, long_done, long_dest, flush,
    output rj_value, rkd_value, ds_ready_go, long_pending
  );
endinterface

// File: rtl/ds_operand_scoreboard.sv
// Decode operand resolution + hazard detection with a registered long-latency-writer scoreboard.
// Zero-latency operand/ready path; DS_BYPASS_EN enables forwarding, otherwise any in-flight writer match stalls.
module ds_operand_scoreboard #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NFWD   = 3
) (
  input logic                   clk,
  input logic                   reset,
  ds_operand_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [NREG-1:0]   sb_q, sb_d;
  logic              rj_nz, rkd_nz, dest_nz;
  logic              rj_hit, rkd_hit;
  logic              rj_fwd_stall, rkd_fwd_stall;
  logic              rj_stall, rkd_stall, waw_stall;
  logic              ds_fire;
`ifdef DS_BYPASS_EN
  logic              rj_sel_rdy, rkd_sel_rdy;
  logic [DATA_W-1:0] rj_sel_dat, rkd_sel_dat;
`else
  logic              unused_fwd;
  assign unused_fwd = ^{bus.fwd_data, bus.fwd_rdy};
`endif

  assign rj_nz   = (bus.rj_addr  != '0);
  assign rkd_nz  = (bus.rkd_addr != '0);
  assign dest_nz = (bus.ds_dest  != '0);

  // Walk from the farthest stage inward so the nearest match (lowest index) wins.
  always_comb begin
    rj_hit  = 1'b0;
    rkd_hit = 1'b0;
`ifdef DS_BYPASS_EN
    rj_sel_rdy  = 1'b1;
    rkd_sel_rdy = 1'b1;
    rj_sel_dat  = '0;
    rkd_sel_dat = '0;
`endif
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (bus.fwd_we[k] && rj_nz && (bus.fwd_dest[k*AW +: AW] == bus.rj_addr)) begin
        rj_hit = 1'b1;
`ifdef DS_BYPASS_EN
        rj_sel_rdy = bus.fwd_rdy[k];
        rj_sel_dat = bus.fwd_data[k*DATA_W +: DATA_W];
`endif
      end
      if (bus.fwd_we[k] && rkd_nz && (bus.fwd_dest[k*AW +: AW] == bus.rkd_addr)) begin
        rkd_hit = 1'b1;
`ifdef DS_BYPASS_EN
        rkd_sel_rdy = bus.fwd_rdy[k];
        rkd_sel_dat = bus.fwd_data[k*DATA_W +: DATA_W];
`endif
      end
    end
  end

`ifdef DS_BYPASS_EN
  assign bus.rj_value   = rj_hit  ? rj_sel_dat  : bus.rf_rdata1;
  assign bus.rkd_value  = rkd_hit ? rkd_sel_dat : bus.rf_rdata2;
  assign rj_fwd_stall   = rj_hit  & ~rj_sel_rdy;
  assign rkd_fwd_stall  = rkd_hit & ~rkd_sel_rdy;
`else
  assign bus.rj_value   = bus.rf_rdata1;
  assign bus.rkd_value  = bus.rf_rdata2;
  assign rj_fwd_stall   = rj_hit;
  assign rkd_fwd_stall  = rkd_hit;
`endif

  // sb_q[0] is never set, so r0 needs no explicit exclusion in these lookups.
  assign rj_stall   = bus.rj_use  & (sb_q[bus.rj_addr]  | rj_fwd_stall);
  assign rkd_stall  = bus.rkd_use & (sb_q[bus.rkd_addr] | rkd_fwd_stall);
  assign waw_stall  = bus.ds_gr_we & sb_q[bus.ds_dest];

  assign bus.ds_ready_go  = ~(rj_stall | rkd_stall | waw_stall);
  assign ds_fire          = bus.ds_valid & bus.ds_ready_go & bus.es_allowin;
  assign bus.long_pending = |sb_q;

  // Clear before set: a same-register collision is impossible because WAW blocks the fire.
  always_comb begin
    sb_d = sb_q;
    if (bus.long_done) begin
      sb_d[bus.long_dest] = 1'b0;
    end
    if (ds_fire && bus.ds_is_long && bus.ds_gr_we && dest_nz) begin
      sb_d[bus.ds_dest] = 1'b1;
    end
    if (bus.flush) begin
      sb_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end
endmodule

// File: tb/tb_ds_operand_scoreboard.sv
// Directed bench for ds_operand_scoreboard: forwarding priority, load-use, long-writer scoreboard,
// flush, r0/unused sources and asynchronous reset; expectations follow the DS_BYPASS_EN build setting.
module tb_ds_operand_scoreboard;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NF = 3;
  localparam int AW = 5;
`ifdef DS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [DW-1:0] RF1 = 32'h1000_0001;
  localparam logic [DW-1:0] RF2 = 32'h2000_0002;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ds_operand_scoreboard_if #(.DATA_W(DW), .NREG(NR), .NFWD(NF)) bus ();

  ds_operand_scoreboard #(.DATA_W(DW), .NREG(NR), .NFWD(NF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic idle();
    bus.ds_valid   = 1'b0;
    bus.es_allowin = 1'b0;
    bus.rj_addr    = '0;
    bus.rkd_addr   = '0;
    bus.rj_use     = 1'b0;
    bus.rkd_use    = 1'b0;
    bus.ds_dest    = '0;
    bus.ds_gr_we   = 1'b0;
    bus.ds_is_long = 1'b0;
    bus.rf_rdata1  = RF1;
    bus.rf_rdata2  = RF2;
    bus.fwd_we     = '0;
    bus.fwd_dest   = '0;
    bus.fwd_data   = '0;
    bus.fwd_rdy    = '0;
    bus.long_done  = 1'b0;
    bus.long_dest  = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic set_fwd(input int k, input logic [AW-1:0] d, input logic [DW-1:0] dat, input logic rdy);
    bus.fwd_we[k]              = 1'b1;
    bus.fwd_dest[k*AW +: AW]   = d;
    bus.fwd_data[k*DW +: DW]   = dat;
    bus.fwd_rdy[k]             = rdy;
  endtask

  task automatic drive_long(input logic [AW-1:0] d, input logic allow);
    bus.ds_valid   = 1'b1;
    bus.es_allowin = allow;
    bus.ds_gr_we   = 1'b1;
    bus.ds_is_long = 1'b1;
    bus.ds_dest    = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.long_pending !== 1'b0) begin
      $display("FAIL reset_pending: got %b expected 0", bus.long_pending); failures++;
    end
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL reset_go: got %b expected 1", bus.ds_ready_go); failures++;
    end
    checks++;
    if (bus.rj_value !== RF1) begin
      $display("FAIL reset_rj_value: got %h expected %h", bus.rj_value, RF1); failures++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_bypass_priority();
    @(negedge clk);
    idle();
    set_fwd(0, 5'd5, 32'h11, 1'b1);
    set_fwd(1, 5'd6, 32'h22, 1'b1);
    set_fwd(2, 5'd5, 32'h33, 1'b1);
    bus.rj_addr = 5'd5;  bus.rj_use = 1'b1;
    bus.rkd_addr = 5'd6; bus.rkd_use = 1'b0;
    #1;
    checks++;
    if (bus.rj_value !== (BYP ? 32'h11 : RF1)) begin
      $display("FAIL prio_rj_value: got %h expected %h", bus.rj_value, (BYP ? 32'h11 : RF1)); failures++;
    end
    checks++;
    if (bus.ds_ready_go !== BYP) begin
      $display("FAIL prio_go: got %b expected %b", bus.ds_ready_go, BYP); failures++;
    end
    checks++;
    if (bus.rkd_value !== (BYP ? 32'h22 : RF2)) begin
      $display("FAIL prio_rkd_value: got %h expected %h", bus.rkd_value, (BYP ? 32'h22 : RF2)); failures++;
    end
    // Nearest stage not ready must stall even though a farther stage is ready.
    bus.fwd_rdy[0] = 1'b0;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0) begin
      $display("FAIL prio_near_notrdy_go: got %b expected 0", bus.ds_ready_go); failures++;
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle();
    set_fwd(0, 5'd7, 32'h0, 1'b0);
    bus.rkd_addr = 5'd7; bus.rkd_use = 1'b1;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0) begin
      $display("FAIL loaduse_stall_go: got %b expected 0", bus.ds_ready_go); failures++;
    end
    @(negedge clk);
    idle();
    set_fwd(1, 5'd7, 32'h77, 1'b1);
    bus.rkd_addr = 5'd7; bus.rkd_use = 1'b1;
    #1;
    checks++;
    if (bus.ds_ready_go !== BYP) begin
      $display("FAIL loaduse_release_go: got %b expected %b", bus.ds_ready_go, BYP); failures++;
    end
    checks++;
    if (bus.rkd_value !== (BYP ? 32'h77 : RF2)) begin
      $display("FAIL loaduse_value: got %h expected %h", bus.rkd_value, (BYP ? 32'h77 : RF2)); failures++;
    end
  endtask

  task automatic test_long_writer();
    // Long writer that is not accepted by execute must not be tracked.
    @(negedge clk);
    idle();
    drive_long(5'd11, 1'b0);
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.long_pending !== 1'b0) begin
      $display("FAIL long_nofire_pending: got %b expected 0", bus.long_pending); failures++;
    end
    drive_long(5'd9, 1'b1);
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL long_fire_go: got %b expected 1", bus.ds_ready_go); failures++;
    end
    @(negedge clk);
    idle();
    bus.rj_addr = 5'd9; bus.rj_use = 1'b1;
    #1;
    checks++;
    if (bus.long_pending !== 1'b1) begin
      $display("FAIL long_pending_set: got %b expected 1", bus.long_pending); failures++;
    end
    checks++;
    if (bus.ds_ready_go !== 1'b0) begin
      $display("FAIL long_reader_stall: got %b expected 0", bus.ds_ready_go); failures++;
    end
    @(negedge clk);
    idle();
    drive_long(5'd9, 1'b1);
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0) begin
      $display("FAIL long_waw_stall: got %b expected 0", bus.ds_ready_go); failures++;
    end
    @(negedge clk);
    idle();
    bus.long_done = 1'b1; bus.long_dest = 5'd9;
    set_fwd(0, 5'd9, 32'h99, 1'b1);
    bus.rj_addr = 5'd9; bus.rj_use = 1'b1;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0) begin
      $display("FAIL long_done_cycle_stall: got %b expected 0", bus.ds_ready_go); failures++;
    end
    // Same edge: clear r9 and set r10.
    bus.rj_use = 1'b0;
    drive_long(5'd10, 1'b1);
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL long_fire_r10_go: got %b expected 1", bus.ds_ready_go); failures++;
    end
    @(negedge clk);
    idle();
    bus.rj_addr = 5'd9; bus.rj_use = 1'b1;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL long_release_go: got %b expected 1", bus.ds_ready_go); failures++;
    end
    checks++;
    if (bus.rj_value !== RF1) begin
      $display("FAIL long_release_value: got %h expected %h", bus.rj_value, RF1); failures++;
    end
    bus.rj_use = 1'b0;
    bus.rkd_addr = 5'd10; bus.rkd_use = 1'b1;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0) begin
      $display("FAIL long_r10_stall: got %b expected 0", bus.ds_ready_go); failures++;
    end
    checks++;
    if (bus.long_pending !== 1'b1) begin
      $display("FAIL long_r10_pending: got %b expected 1", bus.long_pending); failures++;
    end
    @(negedge clk);
    idle();
    bus.long_done = 1'b1; bus.long_dest = 5'd10;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.long_pending !== 1'b0) begin
      $display("FAIL long_all_clear: got %b expected 0", bus.long_pending); failures++;
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle();
    drive_long(5'd3, 1'b1);
    @(negedge clk);
    idle();
    drive_long(5'd4, 1'b1);
    @(negedge clk);
    idle();
    bus.rj_addr = 5'd3; bus.rj_use = 1'b1;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0) begin
      $display("FAIL flush_pre_stall: got %b expected 0", bus.ds_ready_go); failures++;
    end
    // Flush together with a new long fire: flush wins.
    bus.rj_use = 1'b0;
    drive_long(5'd5, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    idle();
    bus.rj_addr = 5'd3; bus.rj_use = 1'b1;
    bus.long_done = 1'b1; bus.long_dest = 5'd4;
    #1;
    checks++;
    if (bus.long_pending !== 1'b0) begin
      $display("FAIL flush_pending: got %b expected 0", bus.long_pending); failures++;
    end
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL flush_reader_go: got %b expected 1", bus.ds_ready_go); failures++;
    end
    checks++;
    if (bus.rj_value !== RF1) begin
      $display("FAIL flush_reader_value: got %h expected %h", bus.rj_value, RF1); failures++;
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.long_pending !== 1'b0) begin
      $display("FAIL flush_late_done: got %b expected 0", bus.long_pending); failures++;
    end
  endtask

  task automatic test_r0_unused();
    @(negedge clk);
    idle();
    set_fwd(0, 5'd0, 32'h55, 1'b0);
    set_fwd(1, 5'd8, 32'h88, 1'b0);
    bus.rj_addr = 5'd0;  bus.rj_use = 1'b1;
    bus.rkd_addr = 5'd8; bus.rkd_use = 1'b0;
    #1;
    checks++;
    if (bus.rj_value !== RF1) begin
      $display("FAIL r0_value: got %h expected %h", bus.rj_value, RF1); failures++;
    end
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL r0_unused_go: got %b expected 1", bus.ds_ready_go); failures++;
    end
    checks++;
    if (bus.rkd_value !== (BYP ? 32'h88 : RF2)) begin
      $display("FAIL unused_fwd_value: got %h expected %h", bus.rkd_value, (BYP ? 32'h88 : RF2)); failures++;
    end
    @(negedge clk);
    idle();
    drive_long(5'd0, 1'b1);
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.long_pending !== 1'b0) begin
      $display("FAIL r0_not_tracked: got %b expected 0", bus.long_pending); failures++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle();
    drive_long(5'd12, 1'b1);
    @(negedge clk);
    idle();
    bus.rj_addr = 5'd12; bus.rj_use = 1'b0;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL unused_pending_go: got %b expected 1", bus.ds_ready_go); failures++;
    end
    bus.rj_use = 1'b1;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0) begin
      $display("FAIL r12_stall: got %b expected 0", bus.ds_ready_go); failures++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.long_pending !== 1'b0) begin
      $display("FAIL async_reset_pending: got %b expected 0", bus.long_pending); failures++;
    end
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL async_reset_go: got %b expected 1", bus.ds_ready_go); failures++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bypass_priority();
    test_load_use();
    test_long_writer();
    test_flush();
    test_r0_unused();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
